mem_unload: RTL

Streams the contents of the 1024-point sample RAM out of the design, the reverse of the memory load path. On request it sweeps the RAM in natural or bit-reversed address order and issues one read per cycle. It absorbs the RAM read latency in a small credit-controlled buffer and presents each word on a valid/ready stream with a last marker. It sits between the FFT/sample RAM read port and any downstream consumer, such as the result dumper or the peak detector.

---
 rtl/mem_unload.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_unload.sv
// mem_unload
//
// Streams the contents of the sample RAM to a downstream consumer. On a
// do_unload request it sweeps the RAM once, in natural or bit-reversed order,
// issuing at most one read per cycle. Read data returns RD_LAT cycles later,
// lands in a small FIFO, and the FIFO head is presented on a valid/ready
// stream. Reads are throttled by a credit check so the FIFO never overflows,
// whatever the consumer does with out_ready.
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          synchronous active-low reset
//   do_unload      level request; starts an unload when sampled high in IDLE
//   mem_addr       RAM read address (bits above LOG2N are 0)
//   mem_rd_en      RAM read strobe, qualifies mem_addr
//   mem_rdata      RAM read data, valid RD_LAT cycles after mem_rd_en
//   out_data       stream data (0 while out_valid is low)
//   out_valid      stream data valid
//   out_ready      consumer accepts the current word
//   out_last       marks the final word of the unload
//   busy           high while reading or draining
//   data_unloaded  high from completion until do_unload is released
module mem_unload #(
    parameter int N_POINTS = 1024,
    parameter int LOG2N    = 10,
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 10,
    parameter int RD_LAT   = 1,
    parameter int BIT_REV  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              do_unload,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              data_unloaded
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Buffer must hold every read that can be outstanding: RD_LAT in the
    // RAM pipeline plus two so a full-rate stream never bubbles.
    localparam int DEPTH = RD_LAT + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [1:0]        state;
    logic [LOG2N:0]    rd_cnt;
    logic [LOG2N-1:0]  out_cnt;
    logic [RD_LAT-1:0] rd_vld_p;
    logic [DATA_W-1:0] fifo_mem [2**PTR_W];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              credit_ok;
    logic              rd_en;
    logic              push;
    logic              pop;
    logic [LOG2N-1:0]  addr_lo;

    function automatic int popcount(input logic [RD_LAT-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        // A same-cycle pop is deliberately not credited, so a push can never
        // land on a full FIFO.
        credit_ok = (int'(fifo_count) + popcount(rd_vld_p)) < DEPTH;
        rd_en     = (state == RUN) && credit_ok;
        push      = rd_vld_p[RD_LAT-1];
        pop       = out_valid && out_ready;
        addr_lo   = (BIT_REV != 0) ? bitrev(rd_cnt[LOG2N-1:0]) : rd_cnt[LOG2N-1:0];
    end

    assign mem_addr      = ADDR_W'(addr_lo);
    assign mem_rd_en     = rd_en;
    assign out_valid     = (fifo_count != '0);
    assign out_data      = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_last      = out_valid && (out_cnt == LOG2N'(N_POINTS - 1));
    assign busy          = (state == RUN) || (state == DRAIN);
    assign data_unloaded = (state == DONE);

    // Stage p0..p(RD_LAT-1): read strobe travelling alongside the RAM pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld_p <= '0;
        end else begin
            rd_vld_p[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
            end
        end
    end

    // FIFO storage: data only, occupancy is tracked by the control below
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
            else if (!push && pop) fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (pop) out_cnt <= out_cnt + LOG2N'(1);
            case (state)
                IDLE: begin
                    if (do_unload) begin
                        state   <= RUN;
                        rd_cnt  <= '0;
                        out_cnt <= '0;
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        rd_cnt <= rd_cnt + (LOG2N+1)'(1);
                        if (rd_cnt == (LOG2N+1)'(N_POINTS - 1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (out_cnt == LOG2N'(N_POINTS - 1))) state <= DONE;
                end
                DONE: begin
                    // Level request must drop before another unload can start.
                    if (!do_unload) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
